apb_servo_array: RTL and testbench

APB3 peripheral driving NUM_CH independent continuous-rotation servos from one shared PWM period timer, the multi-channel successor to the single X/Y servo controller. Each channel supports a commanded pulse width with clamping, tracks full-forward and full-reverse periods, and can perform return-to-zero. Each channel also has two active-low limit inputs that override motion continuously. The block sits on the fabric APB bus next to the other motion peripherals.

---
 rtl/apb_servo_array.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_apb_servo_array.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_servo_array.sv
// ---------------------------------------------------------------------------
// apb_servo_array
//
// APB3 peripheral that drives NUM_CH continuous-rotation servos. All channels
// share a single PWM period timer, so every pulse starts on the same cycle.
// Each channel has:
//   - a commanded pulse width (next_pw), clamped to [PW_MIN, PW_MAX]
//   - saturating counts of full-forward and full-reverse periods
//   - return-to-zero: the channel drives the opposite extreme until the two
//     counts are equal, then parks at neutral
//   - two active-low limit inputs that veto motion toward their side
//
// Ports
//   PCLK, PRESERN        clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB3 control
//   PADDR[31:0]          address, only [11:0] decoded
//   PWDATA, PRDATA       write and read data
//   PREADY               always 1, no wait states
//   PSLVERR              error flag, valid in the access phase
//   limit_n[2*NUM_CH]    bit 2k forward limit, bit 2k+1 reverse limit of ch k
//   pwm_out[NUM_CH]      registered servo PWM outputs
//
// Register map (channel space: PADDR[11:10]==0, ch = PADDR[9:5], reg = [4:2])
//   0 CMD (W)  1 PW (R/W)  2 FWD_CNT (R)  3 REV_CNT (R)  4 STATUS (R)
//   0x400 ALL_NEUTRAL (W, data ignored)
// ---------------------------------------------------------------------------
module apb_servo_array #(
   parameter int NUM_CH     = 4,
   parameter int PWM_PERIOD = 2000000,
   parameter int PW_MIN     = 100000,
   parameter int PW_NEUTRAL = 150000,
   parameter int PW_MAX     = 200000
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                PSEL,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [31:0]         PADDR,
   input  logic [31:0]         PWDATA,
   output logic [31:0]         PRDATA,
   output logic                PREADY,
   output logic                PSLVERR,
   input  logic [2*NUM_CH-1:0] limit_n,
   output logic [NUM_CH-1:0]   pwm_out
);

   localparam int TW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam logic [TW-1:0] LAST_COUNT = TW'(PWM_PERIOD - 1);
   localparam logic [31:0] PMIN = 32'(PW_MIN);
   localparam logic [31:0] PNEU = 32'(PW_NEUTRAL);
   localparam logic [31:0] PMAX = 32'(PW_MAX);

   typedef enum logic [2:0] {
      REG_CMD    = 3'd0,
      REG_PW     = 3'd1,
      REG_FWD    = 3'd2,
      REG_REV    = 3'd3,
      REG_STATUS = 3'd4
   } reg_e;

   typedef enum logic [2:0] {
      CMD_NEUTRAL  = 3'd0,
      CMD_FORWARD  = 3'd1,
      CMD_REVERSE  = 3'd2,
      CMD_SET_ZERO = 3'd3,
      CMD_RTZ      = 3'd4
   } cmd_e;

   // Address decode
   logic        chan_space;
   logic        all_neutral_addr;
   logic [4:0]  sel_ch;
   reg_e        sel_reg;
   logic        ch_ok;
   logic        reg_ok;
   logic        acc_err;
   logic        access_wr;
   logic        setup_rd;
   logic [31:0] rd_val;

   // Shared period timer
   logic [TW-1:0] time_count;
   logic          boundary;

   // Limit synchronisers and decoded active-high limit flags
   logic [2*NUM_CH-1:0] sync1;
   logic [2*NUM_CH-1:0] sync2;
   logic [NUM_CH-1:0]   fwd_lim;
   logic [NUM_CH-1:0]   rev_lim;

   // Per-channel state and its next value
   logic [31:0]       pw_q      [NUM_CH];
   logic [31:0]       next_pw_q [NUM_CH];
   logic [31:0]       fwd_q     [NUM_CH];
   logic [31:0]       rev_q     [NUM_CH];
   logic [NUM_CH-1:0] ret_q;
   logic [NUM_CH-1:0] zp_q;
   logic [31:0]       pw_d      [NUM_CH];
   logic [31:0]       next_pw_d [NUM_CH];
   logic [31:0]       fwd_d     [NUM_CH];
   logic [31:0]       rev_d     [NUM_CH];
   logic [NUM_CH-1:0] ret_d;
   logic [NUM_CH-1:0] zp_d;

   // Address bits outside the decoded window are deliberately ignored.
   logic [21:0] unused_addr;
   assign unused_addr = {PADDR[31:12], PADDR[1:0]};

   assign PREADY = 1'b1;

   function automatic logic [31:0] clamp_pw(input logic [31:0] value);
      if (value < PMIN) return PMIN;
      if (value > PMAX) return PMAX;
      return value;
   endfunction

   // Decode the current APB address. An access is legal only if it hits an
   // existing channel register in the right direction or is a write to
   // ALL_NEUTRAL; everything else is flagged and has no side effects.
   always_comb begin
      chan_space       = (PADDR[11:10] == 2'b00);
      all_neutral_addr = (PADDR[11:2] == 10'h100);
      sel_ch           = PADDR[9:5];
      sel_reg          = reg_e'(PADDR[4:2]);
      ch_ok            = chan_space && ({27'd0, sel_ch} < 32'(NUM_CH));
      reg_ok           = (PADDR[4:2] < 3'd5);
      if (PWRITE)
         acc_err = !((ch_ok && reg_ok && (sel_reg == REG_CMD || sel_reg == REG_PW))
                     || all_neutral_addr);
      else
         acc_err = !(ch_ok && reg_ok && (sel_reg != REG_CMD));
      access_wr = PSEL && PENABLE && PWRITE && !acc_err;
      setup_rd  = PSEL && !PENABLE && !PWRITE;
   end

   // Read mux; illegal reads return all ones.
   always_comb begin
      rd_val = 32'hFFFF_FFFF;
      if (!acc_err) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (sel_ch == 5'(k)) begin
               case (sel_reg)
                  REG_PW:     rd_val = next_pw_q[k];
                  REG_FWD:    rd_val = fwd_q[k];
                  REG_REV:    rd_val = rev_q[k];
                  REG_STATUS: rd_val = {28'd0, rev_lim[k], fwd_lim[k], zp_q[k], ret_q[k]};
                  default:    rd_val = 32'hFFFF_FFFF;
               endcase
            end
         end
      end
   end

   // Split the synchronised limit bus into per-channel active-high flags.
   always_comb begin
      fwd_lim = '0;
      rev_lim = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         fwd_lim[k] = !sync2[2*k];
         rev_lim[k] = !sync2[2*k+1];
      end
   end

   assign boundary = (time_count == LAST_COUNT);

   // Per-channel next-state logic. Order matters: the continuous limit veto
   // is applied first, then the period boundary (which consumes the
   // pre-write next_pw), and finally any register write, so a write landing
   // on the boundary edge is only seen at the following boundary.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         pw_d[k]      = pw_q[k];
         next_pw_d[k] = next_pw_q[k];
         fwd_d[k]     = fwd_q[k];
         rev_d[k]     = rev_q[k];
         ret_d[k]     = ret_q[k];
         zp_d[k]      = zp_q[k];

         if ((fwd_lim[k] && next_pw_q[k] == PMAX) || (rev_lim[k] && next_pw_q[k] == PMIN)) begin
            next_pw_d[k] = PNEU;
            ret_d[k]     = 1'b0;
         end

         if (boundary) begin
            if (zp_q[k]) begin
               fwd_d[k] = '0;
               rev_d[k] = '0;
               pw_d[k]  = PNEU;
               zp_d[k]  = 1'b0;
            end else if (ret_q[k] && fwd_q[k] == rev_q[k]) begin
               ret_d[k]     = 1'b0;
               pw_d[k]      = PNEU;
               next_pw_d[k] = PNEU;
            end else begin
               pw_d[k] = next_pw_q[k];
               if (next_pw_q[k] == PMAX && fwd_q[k] != 32'hFFFF_FFFF)
                  fwd_d[k] = fwd_q[k] + 32'd1;
               if (next_pw_q[k] == PMIN && rev_q[k] != 32'hFFFF_FFFF)
                  rev_d[k] = rev_q[k] + 32'd1;
            end
         end

         if (access_wr) begin
            if (all_neutral_addr) begin
               next_pw_d[k] = PNEU;
               ret_d[k]     = 1'b0;
            end else if (sel_ch == 5'(k)) begin
               if (sel_reg == REG_PW) begin
                  next_pw_d[k] = clamp_pw(PWDATA);
                  ret_d[k]     = 1'b0;
               end else begin
                  case (PWDATA[2:0])
                     CMD_NEUTRAL: begin
                        next_pw_d[k] = PNEU;
                        ret_d[k]     = 1'b0;
                     end
                     CMD_FORWARD: begin
                        next_pw_d[k] = fwd_lim[k] ? PNEU : PMAX;
                        ret_d[k]     = 1'b0;
                     end
                     CMD_REVERSE: begin
                        next_pw_d[k] = rev_lim[k] ? PNEU : PMIN;
                        ret_d[k]     = 1'b0;
                     end
                     CMD_SET_ZERO: begin
                        next_pw_d[k] = PNEU;
                        zp_d[k]      = 1'b1;
                        ret_d[k]     = 1'b0;
                     end
                     CMD_RTZ: begin
                        // Drive back toward the side with fewer periods; a
                        // blocked direction parks at neutral instead.
                        if (fwd_q[k] > rev_q[k]) begin
                           next_pw_d[k] = rev_lim[k] ? PNEU : PMIN;
                           ret_d[k]     = !rev_lim[k];
                        end else if (fwd_q[k] < rev_q[k]) begin
                           next_pw_d[k] = fwd_lim[k] ? PNEU : PMAX;
                           ret_d[k]     = !fwd_lim[k];
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   // Two-flop synchronisers for the asynchronous limit switches; idle high.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= limit_n;
         sync2 <= sync1;
      end
   end

   // Shared period timer and registered PWM outputs. The output for a given
   // time_count value appears one cycle later, so high time equals pw.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         time_count <= '0;
         pwm_out    <= '0;
      end else begin
         time_count <= boundary ? '0 : time_count + 1'b1;
         for (int k = 0; k < NUM_CH; k++)
            pwm_out[k] <= (32'(time_count) < pw_q[k]);
      end
   end

   // Channel state registers.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         for (int k = 0; k < NUM_CH; k++) begin
            pw_q[k]      <= PNEU;
            next_pw_q[k] <= PNEU;
            fwd_q[k]     <= '0;
            rev_q[k]     <= '0;
         end
         ret_q <= '0;
         zp_q  <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            pw_q[k]      <= pw_d[k];
            next_pw_q[k] <= next_pw_d[k];
            fwd_q[k]     <= fwd_d[k];
            rev_q[k]     <= rev_d[k];
         end
         ret_q <= ret_d;
         zp_q  <= zp_d;
      end
   end

   // APB response: read data and error are captured on the setup edge so
   // they are stable throughout the access phase. PRDATA otherwise holds.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         PRDATA  <= '0;
         PSLVERR <= 1'b0;
      end else begin
         PSLVERR <= PSEL && !PENABLE && acc_err;
         if (setup_rd)
            PRDATA <= rd_val;
      end
   end

endmodule

// File: tb/tb_apb_servo_array.sv
// ---------------------------------------------------------------------------
// tb_apb_servo_array
//
// Directed bench for apb_servo_array with a 2-channel, 100-cycle-period
// configuration (PW_MIN 10, PW_NEUTRAL 15, PW_MAX 20). A background monitor
// measures pulse high time and period of each PWM output; commands are
// issued just after a period start so the number of periods each command is
// active for is known exactly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_servo_array;

   localparam int NUM_CH     = 2;
   localparam int PWM_PERIOD = 100;
   localparam int PW_MIN     = 10;
   localparam int PW_NEUTRAL = 15;
   localparam int PW_MAX     = 20;

   localparam logic [2:0] REG_CMD    = 3'd0;
   localparam logic [2:0] REG_PW     = 3'd1;
   localparam logic [2:0] REG_FWD    = 3'd2;
   localparam logic [2:0] REG_REV    = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   logic        pClk;
   logic        pResetN;
   logic        pSel;
   logic        pEnable;
   logic        pWrite;
   logic [31:0] pAddr;
   logic [31:0] pWdata;
   logic [31:0] pRdata;
   logic        pReady;
   logic        pSlvErr;
   logic [3:0]  limitN;
   logic [1:0]  pwmOut;

   int checkCount = 0;
   int failCount  = 0;

   int riseCount  [2];
   int fallCount  [2];
   int highRun    [2];
   int riseGap    [2];
   int lastHigh   [2];
   int lastPeriod [2];
   logic [1:0] prevPwm;

   logic [31:0] rdData;
   logic        errFlag;

   apb_servo_array #(
      .NUM_CH    (NUM_CH),
      .PWM_PERIOD(PWM_PERIOD),
      .PW_MIN    (PW_MIN),
      .PW_NEUTRAL(PW_NEUTRAL),
      .PW_MAX    (PW_MAX)
   ) dut (
      .PCLK   (pClk),
      .PRESERN(pResetN),
      .PSEL   (pSel),
      .PENABLE(pEnable),
      .PWRITE (pWrite),
      .PADDR  (pAddr),
      .PWDATA (pWdata),
      .PRDATA (pRdata),
      .PREADY (pReady),
      .PSLVERR(pSlvErr),
      .limit_n(limitN),
      .pwm_out(pwmOut)
   );

   // 100 MHz-style clock, 10 ns period.
   initial begin
      pClk = 1'b0;
      forever #5 pClk = ~pClk;
   end

   // Pulse monitor: samples on the falling edge, records the high time of
   // the last completed pulse and the rise-to-rise distance per channel.
   always @(negedge pClk) begin
      if (!pResetN) begin
         prevPwm = '0;
         for (int c = 0; c < 2; c++) begin
            highRun[c] = 0;
            riseGap[c] = 0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (pwmOut[c] && !prevPwm[c]) begin
               lastPeriod[c] = riseGap[c];
               riseGap[c]    = 0;
               highRun[c]    = 0;
               riseCount[c]++;
            end
            riseGap[c]++;
            if (pwmOut[c]) highRun[c]++;
            if (!pwmOut[c] && prevPwm[c]) begin
               lastHigh[c] = highRun[c];
               fallCount[c]++;
            end
            prevPwm[c] = pwmOut[c];
         end
      end
   end

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] regAddr(input int ch, input logic [2:0] r);
      return (32'(ch) << 5) | (32'(r) << 2);
   endfunction

   task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data,
                           output logic err);
      @(posedge pClk); #1;
      pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = addr; pWdata = data;
      @(posedge pClk); #1;
      pEnable = 1'b1;
      err = pSlvErr;
      @(posedge pClk); #1;
      pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
   endtask

   task automatic apbRead(input logic [31:0] addr, output logic [31:0] data,
                          output logic err);
      @(posedge pClk); #1;
      pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddr = addr;
      @(posedge pClk); #1;
      pEnable = 1'b1;
      data = pRdata;
      err  = pSlvErr;
      @(posedge pClk); #1;
      pSel = 1'b0; pEnable = 1'b0;
   endtask

   task automatic readCheck(input string tag, input int ch, input logic [2:0] r,
                            input logic [31:0] expected);
      logic [31:0] d;
      logic e;
      apbRead(regAddr(ch, r), d, e);
      checkOutput(tag, d, expected);
   endtask

   // Issue a CMD write to one channel.
   task automatic applyStimulus(input int ch, input logic [31:0] cmd);
      logic e;
      apbWrite(regAddr(ch, REG_CMD), cmd, e);
   endtask

   task automatic waitRises(input int ch, input int n);
      int target;
      target = riseCount[ch] + n;
      for (int i = 0; i < n * 200 && riseCount[ch] < target; i++) @(negedge pClk);
      if (riseCount[ch] < target) checkOutput("rise_timeout", riseCount[ch], target);
   endtask

   task automatic waitFalls(input int ch, input int n);
      int target;
      target = fallCount[ch] + n;
      for (int i = 0; i < n * 200 && fallCount[ch] < target; i++) @(negedge pClk);
      if (fallCount[ch] < target) checkOutput("fall_timeout", fallCount[ch], target);
   endtask

   int pwIn  [3] = '{5, 17, 300};
   int pwExp [3] = '{10, 17, 20};

   initial begin
      pResetN = 1'b0;
      pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
      pAddr = '0; pWdata = '0;
      limitN = 4'hF;

      // Reset state
      repeat (4) @(posedge pClk);
      #1;
      checkOutput("reset_pwm", pwmOut, 2'b00);
      checkOutput("reset_prdata", pRdata, 32'h0);
      checkOutput("reset_pslverr", pSlvErr, 1'b0);
      checkOutput("pready", pReady, 1'b1);
      pResetN = 1'b1;
      @(posedge pClk); #1;
      checkOutput("first_high_edge", pwmOut, 2'b11);

      // Idle: neutral pulses, zero counts
      waitRises(0, 2);
      waitFalls(0, 1);
      checkOutput("idle_high_ch0", lastHigh[0], PW_NEUTRAL);
      checkOutput("idle_high_ch1", lastHigh[1], PW_NEUTRAL);
      checkOutput("idle_period_ch0", lastPeriod[0], PWM_PERIOD);
      readCheck("idle_fwd_ch0", 0, REG_FWD, 0);
      readCheck("idle_rev_ch1", 1, REG_REV, 0);
      readCheck("idle_pw_ch0", 0, REG_PW, PW_NEUTRAL);
      readCheck("idle_status_ch0", 0, REG_STATUS, 0);

      // Forward for exactly three periods, then neutral
      waitRises(0, 1);
      applyStimulus(0, 1);
      waitRises(0, 3);
      applyStimulus(0, 0);
      waitFalls(0, 1);
      checkOutput("fwd_high_ch0", lastHigh[0], PW_MAX);
      checkOutput("fwd_high_ch1", lastHigh[1], PW_NEUTRAL);
      readCheck("fwd_cnt3", 0, REG_FWD, 3);
      waitRises(0, 1);
      waitFalls(0, 1);
      checkOutput("after_fwd_high", lastHigh[0], PW_NEUTRAL);
      readCheck("fwd_cnt_hold", 0, REG_FWD, 3);

      // PW writes with clamping
      for (int i = 0; i < 3; i++) begin
         apbWrite(regAddr(0, REG_PW), pwIn[i], errFlag);
         checkOutput("pw_wr_err", errFlag, 1'b0);
         readCheck("pw_readback", 0, REG_PW, pwExp[i]);
         waitRises(0, 2);
         waitFalls(0, 1);
         checkOutput("pw_pulse", lastHigh[0], pwExp[i]);
      end

      // Set-zero, build fwd=3 rev=1, then return-to-zero
      applyStimulus(0, 3);
      readCheck("zp_status", 0, REG_STATUS, 32'h2);
      waitRises(0, 1);
      readCheck("zp_fwd_clear", 0, REG_FWD, 0);
      readCheck("zp_status_clear", 0, REG_STATUS, 0);
      applyStimulus(0, 1);
      waitRises(0, 3);
      readCheck("rtz_fwd3", 0, REG_FWD, 3);
      applyStimulus(0, 2);
      waitRises(0, 1);
      readCheck("rtz_rev1", 0, REG_REV, 1);
      applyStimulus(0, 4);
      readCheck("rtz_status_ret", 0, REG_STATUS, 32'h1);
      readCheck("rtz_pw_min", 0, REG_PW, PW_MIN);
      waitRises(0, 1);
      readCheck("rtz_rev2", 0, REG_REV, 2);
      waitRises(0, 1);
      readCheck("rtz_rev3", 0, REG_REV, 3);
      readCheck("rtz_status_still", 0, REG_STATUS, 32'h1);
      waitFalls(0, 1);
      checkOutput("rtz_rev_pulse", lastHigh[0], PW_MIN);
      waitRises(0, 1);
      readCheck("rtz_status_done", 0, REG_STATUS, 0);
      readCheck("rtz_pw_neutral", 0, REG_PW, PW_NEUTRAL);
      waitFalls(0, 1);
      checkOutput("rtz_end_pulse", lastHigh[0], PW_NEUTRAL);
      readCheck("rtz_rev_final", 0, REG_REV, 3);

      // Forward limit on channel 1
      waitRises(1, 1);
      applyStimulus(1, 1);
      waitRises(1, 2);
      limitN[2] = 1'b0;
      waitFalls(1, 1);
      checkOutput("lim_pre_pulse", lastHigh[1], PW_MAX);
      waitRises(1, 1);
      waitFalls(1, 1);
      checkOutput("lim_neutral_pulse", lastHigh[1], PW_NEUTRAL);
      readCheck("lim_status", 1, REG_STATUS, 32'h4);
      readCheck("lim_fwd_stop", 1, REG_FWD, 2);
      applyStimulus(1, 1);
      readCheck("lim_fwd_ignored", 1, REG_PW, PW_NEUTRAL);
      applyStimulus(1, 2);
      readCheck("lim_rev_ok", 1, REG_PW, PW_MIN);
      waitRises(1, 2);
      waitFalls(1, 1);
      checkOutput("lim_rev_pulse", lastHigh[1], PW_MIN);
      limitN = 4'hF;

      // ALL_NEUTRAL
      apbWrite(32'h400, 32'hDEAD_BEEF, errFlag);
      checkOutput("alln_err", errFlag, 1'b0);
      readCheck("alln_pw_ch1", 1, REG_PW, PW_NEUTRAL);

      // Error responses
      apbRead(regAddr(5, REG_PW), rdData, errFlag);
      checkOutput("err_ch5_slverr", errFlag, 1'b1);
      checkOutput("err_ch5_data", rdData, 32'hFFFF_FFFF);
      apbWrite(regAddr(0, REG_FWD), 32'h1234, errFlag);
      checkOutput("err_ro_write", errFlag, 1'b1);
      readCheck("err_no_change", 0, REG_FWD, 3);
      apbRead(regAddr(0, 3'd5), rdData, errFlag);
      checkOutput("err_reg5_slverr", errFlag, 1'b1);
      checkOutput("err_reg5_data", rdData, 32'hFFFF_FFFF);
      apbRead(regAddr(0, REG_CMD), rdData, errFlag);
      checkOutput("err_wo_read", errFlag, 1'b1);
      apbRead(regAddr(1, REG_STATUS), rdData, errFlag);
      checkOutput("ok_read_slverr", errFlag, 1'b0);

      // Reset mid-period
      waitRises(0, 1);
      repeat (3) @(posedge pClk);
      #1;
      pResetN = 1'b0;
      #1;
      checkOutput("midreset_pwm", pwmOut, 2'b00);
      checkOutput("midreset_prdata", pRdata, 32'h0);
      repeat (3) @(posedge pClk);
      #1;
      pResetN = 1'b1;
      @(posedge pClk); #1;
      checkOutput("midreset_restart", pwmOut, 2'b11);
      readCheck("midreset_fwd", 0, REG_FWD, 0);
      readCheck("midreset_rev", 0, REG_REV, 0);
      readCheck("midreset_pw", 0, REG_PW, PW_NEUTRAL);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
